// File: rtl/dff_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dff_bank_arbiter
// Description : Round-robin req/gnt arbiter owning one shared WIDTH-bit
//               register. Four requesters compete; the winner's data lane is
//               loaded into q and the grant is held until the winner drops req.
//               Optional macro ARB_TIMEOUT_EN adds a RELEASE watchdog that
//               forces the grant off and raises a sticky err flag.
// Revision    : 1.0 - initial release
// ============================================================================
module dff_bank_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         req,
  input  logic [4*WIDTH-1:0] d,
  output logic [3:0]         gnt,
  output logic [WIDTH-1:0]   q,
  output logic               upd,
  output logic               busy,
  output logic               err
);

  localparam logic [1:0] c_IDLE    = 2'd0;
  localparam logic [1:0] c_GRANT   = 2'd1;
  localparam logic [1:0] c_RELEASE = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [1:0]       r_ptr;
  logic [1:0]       w_ptr_nxt;
  logic [1:0]       r_win;
  logic [1:0]       w_win_nxt;
  logic [3:0]       r_gnt;
  logic [3:0]       w_gnt_nxt;
  logic [WIDTH-1:0] r_q;
  logic             r_upd;
  logic             w_upd_nxt;
  logic             w_load;
  logic [1:0]       w_pick;
  logic             w_found;
  logic             w_timeout;
  logic             w_end;
  logic [WIDTH-1:0] w_lane [4];

  // Split the packed data bus into per-requester lanes
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign w_lane[gi] = d[gi*WIDTH +: WIDTH];
  end

  // Rotating priority: first set request after the last winner, wrapping
  always_comb begin
    w_pick  = r_ptr;
    w_found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      if (!w_found && req[r_ptr + 2'(i)]) begin
        w_pick  = r_ptr + 2'(i);
        w_found = 1'b1;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  // Last count value before the watchdog fires; the edge that would take the
  // counter to 15 is the forced-release edge (15 cycles spent in RELEASE).
  localparam logic [3:0] c_CNT_LAST = 4'd14;

  logic [3:0] r_cnt;
  logic       r_err;

  assign w_timeout = (r_state == c_RELEASE) && req[r_win] && (r_cnt == c_CNT_LAST);

  // RELEASE dwell counter and sticky timeout flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= 4'd0;
      r_err <= 1'b0;
    end else begin
      if (r_state == c_GRANT) begin
        r_cnt <= 4'd0;
      end else if (r_state == c_RELEASE) begin
        r_cnt <= r_cnt + 4'd1;
      end
      if (w_timeout) begin
        r_err <= 1'b1;
      end
    end
  end

  assign err = r_err;
`else
  assign w_timeout = 1'b0;
  assign err       = 1'b0;
`endif

  // Grant ends on withdrawal by the winner or on a watchdog expiry
  assign w_end = (r_state == c_RELEASE) && (!req[r_win] || w_timeout);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:    if (|req) w_state_nxt = c_GRANT;
      c_GRANT:   w_state_nxt = c_RELEASE;
      c_RELEASE: if (w_end) w_state_nxt = c_IDLE;
      default:   w_state_nxt = c_IDLE;
    endcase
  end

  // Output/datapath next values per state
  always_comb begin
    w_gnt_nxt = r_gnt;
    w_upd_nxt = 1'b0;
    w_ptr_nxt = r_ptr;
    w_win_nxt = r_win;
    w_load    = 1'b0;
    case (r_state)
      c_IDLE: begin
        if (|req) begin
          w_gnt_nxt = 4'b0001 << w_pick;
          w_win_nxt = w_pick;
        end else begin
          w_gnt_nxt = 4'b0000;
        end
      end
      c_GRANT: begin
        // Loads even if the winner already withdrew during GRANT
        w_load    = 1'b1;
        w_upd_nxt = 1'b1;
      end
      c_RELEASE: begin
        if (w_end) begin
          w_gnt_nxt = 4'b0000;
          w_ptr_nxt = r_win;
        end
      end
      default: begin
        w_gnt_nxt = 4'b0000;
      end
    endcase
  end

  // Registered outputs, pointer and shared storage; ptr resets to 3 so lane 0 leads
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gnt <= 4'b0000;
      r_upd <= 1'b0;
      r_ptr <= 2'd3;
      r_win <= 2'd0;
      r_q   <= '0;
    end else begin
      r_gnt <= w_gnt_nxt;
      r_upd <= w_upd_nxt;
      r_ptr <= w_ptr_nxt;
      r_win <= w_win_nxt;
      if (w_load) begin
        r_q <= w_lane[r_win];
      end
    end
  end

  assign gnt  = r_gnt;
  assign q    = r_q;
  assign upd  = r_upd;
  assign busy = (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_dff_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dff_bank_arbiter
// Description : Directed self-checking bench for dff_bank_arbiter. Inputs
//               change and outputs are sampled 1 time unit after each rising
//               edge. Covers both builds of ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dff_bank_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] d;
  logic [3:0]  gnt;
  logic [7:0]  q;
  logic        upd;
  logic        busy;
  logic        err;

  int n_pass;
  int n_total;

  dff_bank_arbiter #(.WIDTH(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .d    (d),
    .gnt  (gnt),
    .q    (q),
    .upd  (upd),
    .busy (busy),
    .err  (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    req = 4'b0000;
    d   = 32'h0;
    repeat (10) tick();
    n_total++;
    if (gnt !== 4'b0000 || q !== 8'h00 || upd !== 1'b0 || busy !== 1'b0 || err !== 1'b0)
      $display("FAIL reset_hold gnt=%b q=%h upd=%b busy=%b err=%b, want 0000/00/0/0/0", gnt, q, upd, busy, err);
    else n_pass++;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_total++;
      if (gnt !== 4'b0000 || q !== 8'h00 || upd !== 1'b0 || busy !== 1'b0)
        $display("FAIL reset_idle[%0d] gnt=%b q=%h upd=%b busy=%b, want 0000/00/0/0", i, gnt, q, upd, busy);
      else n_pass++;
    end
  endtask

  task automatic test_single;
    d   = {8'h00, 8'hA5, 8'h00, 8'h00};
    req = 4'b0100;
    tick();
    n_total++;
    if (gnt !== 4'b0100 || busy !== 1'b1 || upd !== 1'b0)
      $display("FAIL single_gnt gnt=%b busy=%b upd=%b, want 0100/1/0", gnt, busy, upd);
    else n_pass++;
    tick();
    n_total++;
    if (q !== 8'hA5 || upd !== 1'b1 || gnt !== 4'b0100)
      $display("FAIL single_load q=%h upd=%b gnt=%b, want a5/1/0100", q, upd, gnt);
    else n_pass++;
    req = 4'b0000;
    tick();
    n_total++;
    if (gnt !== 4'b0000 || upd !== 1'b0 || busy !== 1'b0 || q !== 8'hA5)
      $display("FAIL single_release gnt=%b upd=%b busy=%b q=%h, want 0000/0/0/a5", gnt, upd, busy, q);
    else n_pass++;
  endtask

  task automatic test_rotation;
    logic [1:0] exp_w [5];
    logic [7:0] exp_q [5];
    exp_w = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    exp_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
    rst = 1'b1;
    tick();
    rst = 1'b0;
    d   = {8'h44, 8'h33, 8'h22, 8'h11};
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      tick();
      n_total++;
      if (gnt !== (4'b0001 << exp_w[g]))
        $display("FAIL rot_gnt[%0d] gnt=%b, want lane %0d", g, gnt, exp_w[g]);
      else n_pass++;
      tick();
      n_total++;
      if (q !== exp_q[g] || upd !== 1'b1)
        $display("FAIL rot_q[%0d] q=%h upd=%b, want %h/1", g, q, upd, exp_q[g]);
      else n_pass++;
      tick();
      req[exp_w[g]] = 1'b0;
      tick();
      n_total++;
      if (gnt !== 4'b0000)
        $display("FAIL rot_release[%0d] gnt=%b, want 0000", g, gnt);
      else n_pass++;
      req = 4'b1111;
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_early;
    // Bench is idle here; last winner was lane 0
    d   = {8'h00, 8'h00, 8'h3C, 8'h5A};
    req = 4'b0001;
    tick();
    n_total++;
    if (gnt !== 4'b0001)
      $display("FAIL early_gnt gnt=%b, want 0001", gnt);
    else n_pass++;
    req = 4'b0000;
    tick();
    n_total++;
    if (q !== 8'h5A || upd !== 1'b1 || gnt !== 4'b0001)
      $display("FAIL early_load q=%h upd=%b gnt=%b, want 5a/1/0001", q, upd, gnt);
    else n_pass++;
    tick();
    n_total++;
    if (gnt !== 4'b0000 || busy !== 1'b0)
      $display("FAIL early_release gnt=%b busy=%b, want 0000/0", gnt, busy);
    else n_pass++;
    req = 4'b0011;
    tick();
    n_total++;
    if (gnt !== 4'b0010)
      $display("FAIL early_next gnt=%b, want 0010", gnt);
    else n_pass++;
    tick();
    n_total++;
    if (q !== 8'h3C)
      $display("FAIL early_next_q q=%h, want 3c", q);
    else n_pass++;
    req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_reset_mid;
    // Last winner is lane 1; make lane 1 the only requester
    d   = {8'h99, 8'h00, 8'h77, 8'h00};
    req = 4'b0010;
    tick();
    n_total++;
    if (gnt !== 4'b0010)
      $display("FAIL mid_gnt gnt=%b, want 0010", gnt);
    else n_pass++;
    tick();
    n_total++;
    if (q !== 8'h77 || upd !== 1'b1)
      $display("FAIL mid_load q=%h upd=%b, want 77/1", q, upd);
    else n_pass++;
    #2;
    rst = 1'b1;
    #1;
    n_total++;
    if (gnt !== 4'b0000 || q !== 8'h00 || upd !== 1'b0 || busy !== 1'b0)
      $display("FAIL mid_async gnt=%b q=%h upd=%b busy=%b, want 0000/00/0/0", gnt, q, upd, busy);
    else n_pass++;
    req = 4'b0000;
    tick();
    rst = 1'b0;
    req = 4'b1010;
    tick();
    n_total++;
    if (gnt !== 4'b0010)
      $display("FAIL mid_regrant gnt=%b, want 0010", gnt);
    else n_pass++;
    tick();
    n_total++;
    if (q !== 8'h77)
      $display("FAIL mid_regrant_q q=%h, want 77", q);
    else n_pass++;
    req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_timeout;
    d   = {8'hC3, 8'h00, 8'h00, 8'h00};
    req = 4'b1000;
    tick();
    n_total++;
    if (gnt !== 4'b1000)
      $display("FAIL to_gnt gnt=%b, want 1000", gnt);
    else n_pass++;
`ifdef ARB_TIMEOUT_EN
    // One GRANT cycle plus 15 RELEASE cycles with the grant held
    for (int i = 1; i <= 15; i++) begin
      tick();
      n_total++;
      if (gnt !== 4'b1000 || err !== 1'b0)
        $display("FAIL to_hold[%0d] gnt=%b err=%b, want 1000/0", i, gnt, err);
      else n_pass++;
    end
    tick();
    n_total++;
    if (gnt !== 4'b0000 || err !== 1'b1)
      $display("FAIL to_force gnt=%b err=%b, want 0000/1", gnt, err);
    else n_pass++;
    tick();
    n_total++;
    if (gnt !== 4'b1000 || err !== 1'b1)
      $display("FAIL to_recompete gnt=%b err=%b, want 1000/1", gnt, err);
    else n_pass++;
    req = 4'b0000;
    repeat (3) tick();
    n_total++;
    if (err !== 1'b1 || gnt !== 4'b0000)
      $display("FAIL to_sticky err=%b gnt=%b, want 1/0000", err, gnt);
    else n_pass++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_total++;
    if (err !== 1'b0)
      $display("FAIL to_err_clear err=%b, want 0", err);
    else n_pass++;
`else
    for (int i = 1; i <= 100; i++) begin
      tick();
      n_total++;
      if (gnt !== 4'b1000 || err !== 1'b0)
        $display("FAIL to_hold[%0d] gnt=%b err=%b, want 1000/0", i, gnt, err);
      else n_pass++;
    end
    n_total++;
    if (q !== 8'hC3)
      $display("FAIL to_q q=%h, want c3", q);
    else n_pass++;
    req = 4'b0000;
    tick();
    n_total++;
    if (gnt !== 4'b0000 || err !== 1'b0)
      $display("FAIL to_release gnt=%b err=%b, want 0000/0", gnt, err);
    else n_pass++;
`endif
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst     = 1'b1;
    req     = 4'b0000;
    d       = 32'h0;
    test_reset();
    test_single();
    test_rotation();
    test_early();
    test_reset_mid();
    test_timeout();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
